ram_program_loader: RTL and testbench

- Sits directly upstream of the 16x8 program/data RAM and drives its address, write-data and write-enable inputs while the CPU is held off.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses from 0 to DEPTH-1.
- Reads the image back through the RAM's registered data_out and compares a read-back checksum with the load checksum, then reports pass/fail.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ram_program_loader.sv | 122 ++++++++++++
 tb/tb_ram_program_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU slice: loader FSM states and RAM geometry.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    DONE       = 3'd4
  } state_t;

endpackage

// File: rtl/ram_program_loader.sv
// Loads a DEPTH-byte image into the program RAM over valid/ready, then reads
// it back through the RAM's registered output and compares checksums.
module ram_program_loader #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_data_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [DATA_W-1:0] o_checksum
);
  import cpu_pkg::state_t;
  import cpu_pkg::IDLE;
  import cpu_pkg::LOAD;
  import cpu_pkg::RD_ISSUE;
  import cpu_pkg::RD_CAPTURE;
  import cpu_pkg::DONE;

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_load_sum;
  logic [DATA_W-1:0]   r_rd_sum;
  logic                r_pass;
  logic [DATA_W-1:0]   r_checksum;

  logic                w_in_ready;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rd_sum_next;

  assign w_rd_sum_next = r_rd_sum + i_ram_data_out;

  // Write port is combinational so the RAM captures the byte on the accept edge.
  always_comb begin
    w_in_ready = 1'b0;
    w_we       = 1'b0;
    w_wdata    = {DATA_W{1'b0}};
    if (r_state == LOAD) begin
      w_in_ready = 1'b1;
      w_we       = i_in_valid;
      w_wdata    = i_in_data;
    end else begin
      w_in_ready = 1'b0;
      w_we       = 1'b0;
      w_wdata    = {DATA_W{1'b0}};
    end
  end

  // Loader FSM with the shared address counter and both checksum accumulators.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= {ADDR_W{1'b0}};
      r_load_sum <= {DATA_W{1'b0}};
      r_rd_sum   <= {DATA_W{1'b0}};
      r_pass     <= 1'b0;
      r_checksum <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state    <= LOAD;
            r_cnt      <= {ADDR_W{1'b0}};
            r_load_sum <= {DATA_W{1'b0}};
            r_rd_sum   <= {DATA_W{1'b0}};
            r_pass     <= 1'b0;
          end
        end
        LOAD: begin
          if (i_in_valid) begin
            r_load_sum <= r_load_sum + i_in_data;
            r_cnt      <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          r_state <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          r_rd_sum <= w_rd_sum_next;
          r_cnt    <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state    <= DONE;
            r_pass     <= (w_rd_sum_next == r_load_sum);
            r_checksum <= r_load_sum;
          end else begin
            r_state <= RD_ISSUE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_ram_we    = w_we;
  assign o_ram_wdata = w_wdata;
  assign o_ram_addr  = r_cnt;
  assign o_busy      = (r_state == LOAD) || (r_state == RD_ISSUE) || (r_state == RD_CAPTURE);
  assign o_done      = (r_state == DONE);
  assign o_pass      = r_pass;
  assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed + randomized bench for ram_program_loader with a behavioural RAM
// and a sum-based reference model of the load/verify result.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_data_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] mem [16];
  logic [7:0] img [16];
  bit         fault = 1'b0;
  int         cyc = 0;
  int         last_acc = 0;

  ram_program_loader dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (start),
    .i_in_valid    (in_valid),
    .i_in_data     (in_data),
    .o_in_ready    (in_ready),
    .o_ram_addr    (ram_addr),
    .o_ram_wdata   (ram_wdata),
    .o_ram_we      (ram_we),
    .i_ram_data_out(ram_data_out),
    .o_busy        (busy),
    .o_done        (done),
    .o_pass        (pass),
    .o_checksum    (checksum)
  );

  always #5 clk = ~clk;

  // Behavioural 16x8 RAM with registered read, plus a write log and cycle count.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog.push_back('{addr: ram_addr, data: ram_wdata, cyc: cyc});
    end else begin
      ram_data_out <= (fault && ram_addr == 4'd5) ? 8'hFF : mem[ram_addr];
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] img_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(img[i]);
    return 8'(s);
  endfunction

  task automatic start_pulse();
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer img[0..n-1] with up to maxgap idle cycles before each byte.
  task automatic send_bytes(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int gap;
      int k;
      gap = $urandom_range(maxgap, 0);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = img[i];
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      last_acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done_check(input string tag);
    int         k;
    logic [7:0] exp_sum;
    logic [7:0] rd_sum;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    exp_sum = img_sum();
    rd_sum  = fault ? 8'(exp_sum - img[5] + 8'hFF) : exp_sum;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, 32'(cyc - last_acc), 32'd32);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_checksum"}, {24'd0, checksum}, {24'd0, exp_sum});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, rd_sum == exp_sum});
    chk({tag, "_nwrites"}, 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      chk({tag, "_waddr"}, {28'd0, wlog[i].addr}, 32'(i));
      chk({tag, "_wdata"}, {24'd0, wlog[i].data}, {24'd0, img[i]});
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset held with start and in_valid asserted.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("reset_outputs",
          {7'd0, in_ready, ram_we, ram_addr, ram_wdata, busy, done, pass, checksum}, 32'd0);
    end
    chk("reset_no_write", 32'(wlog.size()), 32'd0);
    start    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {28'd0, in_ready, busy, done, ram_we}, 32'd0);

    // Back-to-back load of 0x00..0x0F.
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    start_pulse();
    chk("load_ready", {31'd0, in_ready}, 32'd1);
    send_bytes(16, 0);
    for (int i = 0; i < 16 && i < wlog.size(); i++)
      chk("b2b_consecutive", 32'(wlog[i].cyc - wlog[0].cyc), 32'(i));
    wait_done_check("b2b");
    chk("b2b_sum_const", {24'd0, checksum}, 32'h78);

    // Backpressure with random valid gaps.
    img = '{8'h1A, 8'h2B, 8'h46, 8'h3C, 8'h2D, 8'hE0, 8'h1E, 8'h2F,
            8'hE0, 8'hF0, 8'h03, 8'h02, 8'h01, 8'h05, 8'h0A, 8'h0B};
    start_pulse();
    chk("bp_done_dropped", {31'd0, done}, 32'd0);
    send_bytes(16, 3);
    wait_done_check("bp");
    chk("bp_sum_const", {24'd0, checksum}, 32'h11);

    // Fault: address 5 reads back 0xFF during verify.
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255, 0));
    if (img[5] == 8'hFF) img[5] = 8'h00;
    fault = 1'b1;
    start_pulse();
    send_bytes(16, 2);
    wait_done_check("fault");
    chk("fault_pass_low", {31'd0, pass}, 32'd0);
    fault = 1'b0;

    // Extra byte after the 16th accept, and start during RD_ISSUE.
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255, 0));
    start_pulse();
    send_bytes(16, 1);
    in_valid = 1'b1;
    in_data  = 8'h99;
    start    = 1'b1;
    #1;
    chk("extra_ready_low", {31'd0, in_ready}, 32'd0);
    chk("extra_no_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("early_start_ignored", {30'd0, busy, done}, 32'd2);
    wait_done_check("extra");

    // Start from DONE begins a fresh load at address 0.
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255, 0));
    start_pulse();
    chk("restart_done_low", {31'd0, done}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_addr0", {28'd0, ram_addr}, 32'd0);
    send_bytes(16, 2);
    wait_done_check("restart");

    // Mid-load reset after 7 accepts, then a full reload.
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255, 0));
    start_pulse();
    send_bytes(7, 1);
    chk("midload_addr", {28'd0, ram_addr}, 32'd7);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_idle", {28'd0, in_ready, busy, done, ram_we}, 32'd0);
    chk("midreset_addr", {28'd0, ram_addr}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255, 0));
    start_pulse();
    send_bytes(16, 2);
    wait_done_check("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
